// File: rtl/downstream_pkg.sv
// Shared types and sizing for the downstream cancel tracker.
package downstream_pkg;

    localparam int unsigned N_CLIENTS = 32;
    localparam int unsigned CLIENT_W  = 5;
    localparam int unsigned AMT_W     = 16;

    localparam logic [AMT_W-1:0] AMT_MAX = {AMT_W{1'b1}};

    typedef struct packed {
        logic [CLIENT_W-1:0] client_id;
        logic [AMT_W-1:0]    amount;
    } cancel_evt_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        UPDATE,
        WRITE
    } ct_state_t;

    // True when the id addresses a real table entry.
    function automatic logic client_valid(input logic [CLIENT_W-1:0] id);
        int unsigned idx;
        idx = 32'(id);
        return idx < N_CLIENTS;
    endfunction

endpackage

// File: rtl/cancel_evt_fifo.sv
// Synchronous FIFO of cancel events with full/empty flags.
module cancel_evt_fifo
    import downstream_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  cancel_evt_t din,
    input  logic        pop,
    output cancel_evt_t dout,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    cancel_evt_t      mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    // No bypass: a push while full is refused even if a pop happens too.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/downstream_cancel_tracker.sv
// Per-client cancelled-order totals fed by an event FIFO and a read-modify-write FSM.
module downstream_cancel_tracker
    import downstream_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                HRESETn,
    input  logic                evt_valid,
    output logic                evt_ready,
    input  logic [CLIENT_W-1:0] evt_client_id,
    input  logic [AMT_W-1:0]    evt_amount,
    input  logic [CLIENT_W-1:0] lkp_client_id,
    output logic [AMT_W-1:0]    cancelled_orders,
    input  logic                clr_valid,
    input  logic [CLIENT_W-1:0] clr_client_id,
    output logic                busy,
    output logic                overflow
);

    cancel_evt_t fifo_din;
    cancel_evt_t fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;

    ct_state_t        state_q;
    cancel_evt_t      hold_q;
    logic [AMT_W-1:0] operand_q;
    logic [AMT_W-1:0] result_q;
    logic [AMT_W-1:0] lookup_q;
    logic             overflow_q;
    logic [AMT_W-1:0] table_q [N_CLIENTS];

    logic             hold_ok;
    logic             clr_ok;
    logic             clr_hit;
    logic [AMT_W-1:0] read_val;
    logic [AMT_W-1:0] operand_eff;
    logic [AMT_W:0]   sum;
    logic             wr_en;
    logic [AMT_W-1:0] wr_val;
    logic [AMT_W-1:0] lookup_next;

    assign fifo_din.client_id = evt_client_id;
    assign fifo_din.amount    = evt_amount;
    assign evt_ready          = !fifo_full;
    assign fifo_push          = evt_valid && evt_ready;
    assign fifo_pop           = (state_q == IDLE) && !fifo_empty;

    cancel_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (HRESETn),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Shared decode of the in-flight event against the clear request.
    always_comb begin
        hold_ok     = client_valid(hold_q.client_id);
        clr_ok      = clr_valid && client_valid(clr_client_id);
        clr_hit     = clr_ok && (clr_client_id == hold_q.client_id);
        read_val    = hold_ok ? table_q[hold_q.client_id] : '0;
        // A clear landing during UPDATE drops the prior total already latched.
        operand_eff = clr_hit ? '0 : operand_q;
        sum         = {1'b0, operand_eff} + {1'b0, hold_q.amount};
        wr_en       = (state_q == WRITE) && hold_ok;
        // A clear landing during WRITE keeps the event but not the prior total.
        wr_val      = clr_hit ? hold_q.amount : result_q;
    end

    // Lookup value as the table will read after this edge (write/clear forwarded).
    always_comb begin
        lookup_next = '0;
        if (client_valid(lkp_client_id)) begin
            if (wr_en && (hold_q.client_id == lkp_client_id)) begin
                lookup_next = wr_val;
            end else if (clr_ok && (clr_client_id == lkp_client_id)) begin
                lookup_next = '0;
            end else begin
                lookup_next = table_q[lkp_client_id];
            end
        end
    end

    // Event processing FSM: pop, read operand, add with saturation, then write back.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            operand_q  <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        hold_q  <= fifo_dout;
                        state_q <= READ;
                    end
                end
                READ: begin
                    operand_q <= clr_hit ? '0 : read_val;
                    state_q   <= UPDATE;
                end
                UPDATE: begin
                    if (sum[AMT_W]) begin
                        result_q <= AMT_MAX;
                        if (hold_ok) overflow_q <= 1'b1;
                    end else begin
                        result_q <= sum[AMT_W-1:0];
                    end
                    state_q <= WRITE;
                end
                WRITE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Client table: write-back takes priority over a clear of the same entry.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int unsigned i = 0; i < N_CLIENTS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CLIENTS; i++) begin
                if (wr_en && (hold_q.client_id == CLIENT_W'(i))) begin
                    table_q[i] <= wr_val;
                end else if (clr_ok && (clr_client_id == CLIENT_W'(i))) begin
                    table_q[i] <= '0;
                end
            end
        end
    end

    // Registered lookup port, one cycle of latency.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            lookup_q <= '0;
        end else begin
            lookup_q <= lookup_next;
        end
    end

    assign cancelled_orders = lookup_q;
    assign overflow         = overflow_q;
    assign busy             = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_downstream_cancel_tracker.sv
// Randomized and directed bench for downstream_cancel_tracker with a queue-based reference model.
module tb_downstream_cancel_tracker;
    import downstream_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXV  = 32'hFFFF;

    logic                clk = 1'b0;
    logic                HRESETn;
    logic                evt_valid;
    logic                evt_ready;
    logic [CLIENT_W-1:0] evt_client_id;
    logic [AMT_W-1:0]    evt_amount;
    logic [CLIENT_W-1:0] lkp_client_id;
    logic [AMT_W-1:0]    cancelled_orders;
    logic                clr_valid;
    logic [CLIENT_W-1:0] clr_client_id;
    logic                busy;
    logic                overflow;

    downstream_cancel_tracker #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .HRESETn          (HRESETn),
        .evt_valid        (evt_valid),
        .evt_ready        (evt_ready),
        .evt_client_id    (evt_client_id),
        .evt_amount       (evt_amount),
        .lkp_client_id    (lkp_client_id),
        .cancelled_orders (cancelled_orders),
        .clr_valid        (clr_valid),
        .clr_client_id    (clr_client_id),
        .busy             (busy),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: totals per client, pending events, and a 4-cycle server.
    int unsigned m_tbl [32];
    int unsigned m_q_id [$];
    int unsigned m_q_amt [$];
    int unsigned m_svc;
    int unsigned m_cur_id;
    int unsigned m_cur_amt;
    logic        m_ovf;
    logic        last_push;
    logic        saw_not_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_tbl[i] = 0;
        m_q_id.delete();
        m_q_amt.delete();
        m_svc     = 0;
        m_cur_id  = 0;
        m_cur_amt = 0;
        m_ovf     = 1'b0;
    endtask

    // One clock: drive inputs, predict, check ready/busy before and lookup/overflow after.
    task automatic step(input logic v, input int unsigned id, input int unsigned amt,
                        input int unsigned lk, input logic cv, input int unsigned cid);
        int unsigned exp;
        int unsigned s;
        evt_valid     = v;
        evt_client_id = id[CLIENT_W-1:0];
        evt_amount    = amt[AMT_W-1:0];
        lkp_client_id = lk[CLIENT_W-1:0];
        clr_valid     = cv;
        clr_client_id = cid[CLIENT_W-1:0];
        @(negedge clk);
        check("ready", evt_ready, 32'(m_q_id.size() < DEPTH));
        check("busy", busy, 32'((m_q_id.size() > 0) || (m_svc > 0)));
        if (!evt_ready) saw_not_ready = 1'b1;
        last_push = v && (m_q_id.size() < DEPTH);
        if (cv) m_tbl[cid] = 0;
        if (m_svc == 2 && (m_tbl[m_cur_id] + m_cur_amt > MAXV)) m_ovf = 1'b1;
        if (m_svc == 1) begin
            s = m_tbl[m_cur_id] + m_cur_amt;
            m_tbl[m_cur_id] = (s > MAXV) ? MAXV : s;
        end
        if (m_svc == 0 && m_q_id.size() > 0) begin
            m_cur_id  = m_q_id.pop_front();
            m_cur_amt = m_q_amt.pop_front();
            m_svc     = 3;
        end else if (m_svc > 0) begin
            m_svc--;
        end
        if (last_push) begin
            m_q_id.push_back(id);
            m_q_amt.push_back(amt);
        end
        exp = m_tbl[lk];
        @(posedge clk);
        #1;
        check("lookup", cancelled_orders, exp);
        check("overflow", overflow, 32'(m_ovf));
    endtask

    task automatic idle(input int unsigned lk);
        step(1'b0, 0, 0, lk, 1'b0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 100) begin
            idle(n % 32);
            n++;
        end
        check("drain_done", busy, 0);
    endtask

    task automatic do_reset();
        HRESETn       = 1'b0;
        evt_valid     = 1'b0;
        evt_client_id = '0;
        evt_amount    = '0;
        lkp_client_id = '0;
        clr_valid     = 1'b0;
        clr_client_id = '0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_ready", evt_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_lkp", cancelled_orders, 0);
        @(negedge clk);
        HRESETn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned ids  [6];
        int unsigned amts [6];
        int          tries;
        ids  = '{10, 11, 10, 12, 11, 10};
        amts = '{5, 6, 7, 8, 9, 10};
        saw_not_ready = 1'b0;
        last_push     = 1'b0;

        // Reset state and empty lookups.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            idle(i);
            check("t1_zero", cancelled_orders, 0);
        end

        // Two events to one client; busy timing.
        do_reset();
        step(1'b1, 3, 100, 3, 1'b0, 0);
        step(1'b1, 3, 50, 3, 1'b0, 0);
        for (int i = 0; i < 6; i++) idle(3);
        check("t2_busy_hi", busy, 1);
        idle(3);
        check("t2_busy_lo", busy, 0);
        check("t2_total", cancelled_orders, 150);

        // Burst beyond FIFO depth.
        do_reset();
        saw_not_ready = 1'b0;
        for (int e = 0; e < 6; e++) begin
            tries = 0;
            last_push = 1'b0;
            while (!last_push && tries < 50) begin
                step(1'b1, ids[e], amts[e], 10, 1'b0, 0);
                tries++;
            end
            check("t3_accept", 32'(last_push), 1);
        end
        drain();
        check("t3_ready_dropped", saw_not_ready, 1);
        idle(10);
        check("t3_c10", cancelled_orders, 22);
        idle(11);
        check("t3_c11", cancelled_orders, 15);
        idle(12);
        check("t3_c12", cancelled_orders, 8);

        // Saturation and sticky overflow.
        do_reset();
        step(1'b1, 7, 'hFFF0, 7, 1'b0, 0);
        drain();
        step(1'b1, 7, 'h20, 7, 1'b0, 0);
        drain();
        idle(7);
        check("t4_sat", cancelled_orders, 'hFFFF);
        check("t4_ovf", overflow, 1);
        step(1'b0, 0, 0, 7, 1'b1, 7);
        check("t4_clr", cancelled_orders, 0);
        check("t4_ovf_sticky", overflow, 1);

        // Clear racing the in-flight event: during READ, then during WRITE.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            step(1'b1, 5, 70, 5, 1'b0, 0);
            drain();
            step(1'b1, 5, 40, 5, 1'b0, 0);
            idle(5);
            if (r == 0) begin
                step(1'b0, 0, 0, 5, 1'b1, 5);
                idle(5);
                idle(5);
            end else begin
                idle(5);
                idle(5);
                step(1'b0, 0, 0, 5, 1'b1, 5);
            end
            drain();
            idle(5);
            check("t5_clr_race", cancelled_orders, 40);
        end

        // Lookup forwarded from the WRITE cycle.
        do_reset();
        step(1'b1, 9, 10, 9, 1'b0, 0);
        drain();
        step(1'b1, 9, 25, 9, 1'b0, 0);
        idle(9);
        idle(9);
        idle(9);
        idle(9);
        check("t6_fwd", cancelled_orders, 35);

        // Reset asserted while the event sits in UPDATE.
        do_reset();
        step(1'b1, 2, 77, 2, 1'b0, 0);
        idle(2);
        idle(2);
        HRESETn = 1'b0;
        #1;
        model_reset();
        check("t7_busy", busy, 0);
        check("t7_ready", evt_ready, 1);
        check("t7_lkp", cancelled_orders, 0);
        #2;
        HRESETn = 1'b1;
        drain();
        idle(2);
        check("t7_discard", cancelled_orders, 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom % 2), $urandom % 32, $urandom % 256, $urandom % 32,
                 1'(($urandom % 20) == 0), $urandom % 32);
        end
        drain();
        for (int i = 0; i < 32; i++) idle(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
